// File: rtl/stepper_phase_decoder_pkg.sv
// Shared definitions for the stepper coil-phase decoder and the stepper driver:
// legal coil patterns, fault codes, FSM states and rotation helpers.
package stepper_phase_decoder_pkg;

    localparam logic [3:0] PH_A = 4'b1001;
    localparam logic [3:0] PH_B = 4'b1100;
    localparam logic [3:0] PH_C = 4'b0110;
    localparam logic [3:0] PH_D = 4'b0011;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_SKIP    = 2'b10
    } fault_code_t;

    typedef enum logic [1:0] {
        ST_UNSYNC,
        ST_TRACK,
        ST_FAULT
    } state_t;

    // Forward rotation: 1001 -> 1100 -> 0110 -> 0011 -> 1001
    function automatic logic [3:0] rot_right(input logic [3:0] p);
        return {p[0], p[3:1]};
    endfunction

    function automatic logic [3:0] rot_left(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

    function automatic logic is_legal(input logic [3:0] p);
        return (p == PH_A) || (p == PH_B) || (p == PH_C) || (p == PH_D);
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_filter.sv
// Two-flop synchronizer plus stability filter; pulses accept once per newly
// stable pattern after FILTER_CYC consecutive equal synchronized samples.
module phase_filter #(
    parameter int FILTER_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] phase_in,
    output logic       accept,
    output logic [3:0] pattern
);

    localparam int CW = $clog2(FILTER_CYC + 1);

    logic [3:0]    sync1_q, sync2_q, last_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          changed, accept_d;

    always_comb begin
        changed  = (sync2_q != last_q);
        cnt_d    = cnt_q;
        if (changed)
            cnt_d = CW'(1);
        else if (cnt_q != CW'(FILTER_CYC))
            cnt_d = cnt_q + CW'(1);
        // pulse only on the cycle the count first reaches the threshold
        accept_d = (cnt_d == CW'(FILTER_CYC)) && (changed || cnt_q != CW'(FILTER_CYC));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            accept  <= 1'b0;
        end else begin
            sync1_q <= phase_in;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            cnt_q   <= cnt_d;
            accept  <= accept_d;
        end
    end

    assign pattern = last_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes filtered stepper coil patterns into an absolute position with
// hour index, direction, overtravel and latched fault reporting.
module stepper_phase_decoder
    import stepper_phase_decoder_pkg::*;
#(
    parameter int STEPS_PER_HOUR = 8,
    parameter int MAX_HOURS      = 12,
    parameter int FILTER_CYC     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] phase_in,
    input  logic       fault_clr,
    output logic [7:0] position,
    output logic [3:0] hour_idx,
    output logic       step_pulse,
    output logic       direction,
    output logic       synced,
    output logic       home,
    output logic       overtravel,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int MAX_POS = STEPS_PER_HOUR * MAX_HOURS;
    localparam int SW      = (STEPS_PER_HOUR > 1) ? $clog2(STEPS_PER_HOUR) : 1;

    logic        acc;
    logic [3:0]  acc_pat;

    state_t      state_q, state_d;
    fault_code_t fcode_q, fcode_d;
    logic [3:0]  ref_q, ref_d;
    logic [7:0]  pos_q, pos_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [3:0]  hour_q, hour_d;
    logic        dir_q, dir_d, step_q, step_d, ovt_q, ovt_d;

    phase_filter #(.FILTER_CYC(FILTER_CYC)) u_filter (
        .clk      (clk),
        .reset    (reset),
        .phase_in (phase_in),
        .accept   (acc),
        .pattern  (acc_pat)
    );

    always_comb begin
        state_d = state_q;
        fcode_d = fcode_q;
        ref_d   = ref_q;
        pos_d   = pos_q;
        sub_d   = sub_q;
        hour_d  = hour_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        ovt_d   = 1'b0;
        case (state_q)
            ST_UNSYNC: begin
                if (acc && is_legal(acc_pat)) begin
                    ref_d   = acc_pat;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (acc && acc_pat != ref_q) begin
                    if (!is_legal(acc_pat)) begin
                        state_d = ST_FAULT;
                        fcode_d = FC_ILLEGAL;
                    end else if (acc_pat == rot_right(ref_q)) begin
                        ref_d = acc_pat;
                        if (pos_q == 8'(MAX_POS)) begin
                            ovt_d = 1'b1;
                        end else begin
                            pos_d  = pos_q + 8'd1;
                            dir_d  = 1'b1;
                            step_d = 1'b1;
                            if (sub_q == SW'(STEPS_PER_HOUR - 1)) begin
                                sub_d  = '0;
                                hour_d = hour_q + 4'd1;
                            end else begin
                                sub_d  = sub_q + SW'(1);
                            end
                        end
                    end else if (acc_pat == rot_left(ref_q)) begin
                        ref_d = acc_pat;
                        if (pos_q == '0) begin
                            ovt_d = 1'b1;
                        end else begin
                            pos_d  = pos_q - 8'd1;
                            dir_d  = 1'b0;
                            step_d = 1'b1;
                            if (sub_q == '0) begin
                                sub_d  = SW'(STEPS_PER_HOUR - 1);
                                hour_d = hour_q - 4'd1;
                            end else begin
                                sub_d  = sub_q - SW'(1);
                            end
                        end
                    end else begin
                        state_d = ST_FAULT;
                        fcode_d = FC_SKIP;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_UNSYNC;
                    fcode_d = FC_NONE;
                end
            end
            default: state_d = ST_UNSYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_UNSYNC;
            fcode_q <= FC_NONE;
            ref_q   <= '0;
            pos_q   <= '0;
            sub_q   <= '0;
            hour_q  <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            ovt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcode_q <= fcode_d;
            ref_q   <= ref_d;
            pos_q   <= pos_d;
            sub_q   <= sub_d;
            hour_q  <= hour_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            ovt_q   <= ovt_d;
        end
    end

    assign position   = pos_q;
    assign hour_idx   = hour_q;
    assign step_pulse = step_q;
    assign direction  = dir_q;
    assign overtravel = ovt_q;
    assign synced     = (state_q == ST_TRACK);
    assign home       = synced && (pos_q == '0);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fcode_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder with hand-computed expectations.
module tb_stepper_phase_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] phase_in;
    logic       fault_clr;
    logic [7:0] position;
    logic [3:0] hour_idx;
    logic       step_pulse, direction, synced, home, overtravel, fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;
    int step_cnt, ovt_cnt, both_cnt;
    logic [3:0] p;
    logic [4:0] lat;

    always #5 clk = ~clk;

    stepper_phase_decoder #(
        .STEPS_PER_HOUR (8),
        .MAX_HOURS      (12),
        .FILTER_CYC     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .phase_in   (phase_in),
        .fault_clr  (fault_clr),
        .position   (position),
        .hour_idx   (hour_idx),
        .step_pulse (step_pulse),
        .direction  (direction),
        .synced     (synced),
        .home       (home),
        .overtravel (overtravel),
        .fault      (fault),
        .fault_code (fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] pat, input int n);
        phase_in = pat;
        repeat (n) begin
            @(negedge clk);
            step_cnt += int'(step_pulse);
            ovt_cnt  += int'(overtravel);
            both_cnt += int'(step_pulse & overtravel);
        end
    endtask

    function automatic logic [3:0] rr(input logic [3:0] x);
        return {x[0], x[3:1]};
    endfunction

    function automatic logic [3:0] rl(input logic [3:0] x);
        return {x[2:0], x[3]};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pos"},   32'(position),   32'd0);
        chk({tag, "_hour"},  32'(hour_idx),   32'd0);
        chk({tag, "_step"},  32'(step_pulse), 32'd0);
        chk({tag, "_dir"},   32'(direction),  32'd0);
        chk({tag, "_sync"},  32'(synced),     32'd0);
        chk({tag, "_home"},  32'(home),       32'd0);
        chk({tag, "_ovt"},   32'(overtravel), 32'd0);
        chk({tag, "_fault"}, 32'(fault),      32'd0);
        chk({tag, "_fcode"}, 32'(fault_code), 32'd0);
    endtask

    initial begin
        reset = 1'b1; fault_clr = 1'b0; phase_in = 4'b1001;
        step_cnt = 0; ovt_cnt = 0; both_cnt = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        // Initial sync on 1001
        reset = 1'b0;
        run(4'b1001, 10);
        chk("sync_synced", 32'(synced), 32'd1);
        chk("sync_home", 32'(home), 32'd1);
        chk("sync_pos", 32'(position), 32'd0);
        chk("sync_nostep", 32'(step_cnt), 32'd0);

        // First forward step: pulse visible after the 5th falling edge only
        phase_in = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lat[i] = step_pulse;
            step_cnt += int'(step_pulse);
        end
        chk("latency", 32'(lat), 32'b10000);
        run(4'b0110, 5);
        run(4'b0011, 5);
        run(4'b1001, 5);
        chk("fwd4_steps", 32'(step_cnt), 32'd4);
        chk("fwd4_dir", 32'(direction), 32'd1);
        chk("fwd4_pos", 32'(position), 32'd4);
        chk("fwd4_hour", 32'(hour_idx), 32'd0);

        p = 4'b1001;
        repeat (4) begin p = rr(p); run(p, 5); end
        chk("fwd8_steps", 32'(step_cnt), 32'd8);
        chk("fwd8_pos", 32'(position), 32'd8);
        chk("fwd8_hour", 32'(hour_idx), 32'd1);

        // fault_clr while tracking is ignored
        fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0; @(negedge clk);
        chk("clr_track_sync", 32'(synced), 32'd1);
        chk("clr_track_fault", 32'(fault), 32'd0);

        repeat (8) begin p = rl(p); run(p, 5); end
        chk("rev_pos", 32'(position), 32'd0);
        chk("rev_dir", 32'(direction), 32'd0);
        chk("rev_hour", 32'(hour_idx), 32'd0);
        chk("rev_home", 32'(home), 32'd1);

        // Reverse at position 0 -> overtravel
        step_cnt = 0; ovt_cnt = 0;
        p = rl(p);
        run(p, 8);
        chk("ovt0_pulse", 32'(ovt_cnt), 32'd1);
        chk("ovt0_nostep", 32'(step_cnt), 32'd0);
        chk("ovt0_pos", 32'(position), 32'd0);
        chk("ovt0_sync", 32'(synced), 32'd1);

        p = rr(p);
        run(p, 6);
        chk("after_ovt_pos", 32'(position), 32'd1);

        // One-cycle glitch
        step_cnt = 0;
        run(4'b1100, 1);
        run(4'b1001, 8);
        chk("glitch_nostep", 32'(step_cnt), 32'd0);
        chk("glitch_pos", 32'(position), 32'd1);

        // Skipped step fault
        run(4'b1100, 6);
        run(4'b0011, 6);
        chk("skip_fault", 32'(fault), 32'd1);
        chk("skip_code", 32'(fault_code), 32'd2);
        chk("skip_pos", 32'(position), 32'd2);
        chk("skip_sync", 32'(synced), 32'd0);

        fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_code", 32'(fault_code), 32'd0);
        chk("clr_pos", 32'(position), 32'd2);
        run(4'b0101, 10);
        chk("illegal_unsync", 32'(synced), 32'd0);
        chk("illegal_nofault", 32'(fault), 32'd0);
        run(4'b0110, 10);
        chk("resync", 32'(synced), 32'd1);
        chk("resync_pos", 32'(position), 32'd2);

        // Sweep to the upper end and overtravel there
        p = 4'b0110;
        repeat (94) begin p = rr(p); run(p, 5); end
        chk("max_pos", 32'(position), 32'd96);
        chk("max_hour", 32'(hour_idx), 32'd12);
        step_cnt = 0; ovt_cnt = 0;
        p = rr(p);
        run(p, 8);
        chk("ovtmax_pulse", 32'(ovt_cnt), 32'd1);
        chk("ovtmax_nostep", 32'(step_cnt), 32'd0);
        chk("ovtmax_pos", 32'(position), 32'd96);
        chk("ovtmax_sync", 32'(synced), 32'd1);

        repeat (46) begin p = rl(p); run(p, 5); end
        chk("p50_pos", 32'(position), 32'd50);
        chk("p50_hour", 32'(hour_idx), 32'd6);
        chk("p50_dir", 32'(direction), 32'd0);
        chk("never_both", 32'(both_cnt), 32'd0);

        // Reset while a new pattern is still in the filter
        phase_in = rl(p);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_unsync", 32'(synced), 32'd0);
        chk("postrst_pos", 32'(position), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
